// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump engine: FSM states and the
// default widths (narrow widths under the FPGA board build macro).
package reg_dump_reader_pkg;

`ifdef FPGA_BUILD
  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 2;
`else
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready stream of (address, data) pairs from the dump engine to the
// debug/host link.
interface reg_dump_reader_if
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid, out_addr, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_addr, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks every register-file address on a start pulse, streams (addr, data)
// pairs out, keeps an XOR checksum and freezes the pipeline while active.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  freeze_req,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  reg_dump_reader_if.master     dump,
  output logic [DATA_WIDTH-1:0] checksum
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] oaddr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  last_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = SEND;
      SEND:    if (dump.out_ready) state_d = last_q ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    freeze_req     = busy;
    done           = (state_q == DONE);
    dump.out_valid = (state_q == SEND);
    dump.out_last  = dump.out_valid & last_q;
    dump.out_addr  = oaddr_q;
    dump.out_data  = data_q;
    rf_raddr       = addr_q;
    checksum       = csum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      oaddr_q <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= '0;
            csum_q <= '0;
          end
        end
        FETCH: begin
          data_q  <= rf_rdata;
          oaddr_q <= addr_q;
          last_q  <= (addr_q == '1);
        end
        SEND: begin
          // Counter stops on the final index so the walk never wraps.
          if (dump.out_ready) begin
            csum_q <= csum_q ^ data_q;
            if (!last_q) addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          // Return the read address to 0 so it idles at 0.
          addr_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: full-width instance plus a narrow
// (4-bit data, 4-entry) instance.
module tb_reg_dump_reader;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned N   = 1 << AW;
  localparam int unsigned SDW = 4;
  localparam int unsigned SAW = 2;
  localparam int unsigned SN  = 1 << SAW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start_s;
  logic          busy, freeze_req, done;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata, checksum;
  logic [DW-1:0] regs [N];
  assign rf_rdata = regs[rf_raddr];

  logic           s_busy, s_freeze, s_done;
  logic [SAW-1:0] s_raddr;
  logic [SDW-1:0] s_rdata, s_checksum;
  logic [SDW-1:0] sregs [SN];
  assign s_rdata = sregs[s_raddr];

  reg_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dif ();
  reg_dump_reader_if #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW)) sif ();

  reg_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .freeze_req(freeze_req),
    .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump(dif),
    .checksum(checksum)
  );

  reg_dump_reader #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(s_busy), .freeze_req(s_freeze),
    .done(s_done), .rf_raddr(s_raddr), .rf_rdata(s_rdata), .dump(sif),
    .checksum(s_checksum)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  word_t         expq[$];
  int            words_seen = 0;
  int            done_cnt   = 0;
  bit            ready_mode = 0;
  bit            stalled    = 0;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  initial begin
    dif.out_ready = 1'b1;
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dif.out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshakes pop the scoreboard; stalls must hold the word steady.
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      stalled = 0;
    end else begin
      if (done) done_cnt++;
      if (stalled) begin
        check("stall_valid", 64'(dif.out_valid), 64'(1));
        check("stall_addr", 64'(dif.out_addr), 64'(hold_a));
        check("stall_data", 64'(dif.out_data), 64'(hold_d));
        check("stall_last", 64'(dif.out_last), 64'(hold_l));
      end
      if (dif.out_valid) check("freeze_in_dump", 64'(freeze_req), 64'(1));
      if (dif.out_valid && dif.out_ready) begin
        stalled = 0;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got addr %0h data %0h want none", dif.out_addr, dif.out_data);
        end else begin
          w = expq.pop_front();
          check("word_addr", 64'(dif.out_addr), 64'(w.a));
          check("word_data", 64'(dif.out_data), 64'(w.d));
          check("word_last", 64'(dif.out_last), 64'(w.l));
        end
        words_seen++;
      end else if (dif.out_valid) begin
        stalled = 1;
        hold_a  = dif.out_addr;
        hold_d  = dif.out_data;
        hold_l  = dif.out_last;
      end else begin
        stalled = 0;
      end
    end
  end

  // One dump on the wide instance. restart_at: pulse start after that many
  // words; rst_at: reset while that word is offered; timed: expect full rate.
  task automatic run_dump(input int restart_at, input int rst_at, input bit timed,
                          output logic [DW-1:0] csum_exp);
    int n      = 0;
    bit pulsed = 0;
    bit got    = 0;
    csum_exp   = '0;
    expq.delete();
    words_seen = 0;
    done_cnt   = 0;
    for (int i = 0; i < int'(N); i++) begin
      expq.push_back({AW'(i), regs[i], 1'(i == int'(N) - 1)});
      csum_exp ^= regs[i];
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!got && n < 4000) begin
      if (restart_at >= 0 && !pulsed && words_seen == restart_at) begin
        start  = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (rst_at >= 0 && words_seen == rst_at && dif.out_valid) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 64'(dif.out_valid), 64'(0));
        check("rst_checksum", 64'(checksum), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_raddr", 64'(rf_raddr), 64'(0));
        check("rst_out_data", 64'(dif.out_data), 64'(0));
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt), 64'(0));
        check("rst_stays_idle", 64'(busy), 64'(0));
        expq.delete();
        return;
      end
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", n);
      return;
    end
    if (timed) check("done_cycle", 64'(n), 64'(2 * N));
    check("checksum", 64'(checksum), 64'(csum_exp));
    check("all_words_sent", 64'(expq.size()), 64'(0));
    check("busy_in_done", 64'(freeze_req), 64'(1));
    @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_freeze", 64'(freeze_req), 64'(0));
    check("done_pulse_once", 64'(done_cnt), 64'(1));
    check("idle_raddr", 64'(rf_raddr), 64'(0));
    check("checksum_held", 64'(checksum), 64'(csum_exp));
  endtask

  initial begin
    logic [DW-1:0] c1, c2, ca, cb, old3;
    logic [SDW-1:0] scs;
    rst     = 1'b1;
    start   = 1'b0;
    start_s = 1'b0;
    for (int i = 0; i < int'(N); i++) regs[i] = (i == 0) ? '0 : DW'(32'h100 + i);
    for (int i = 0; i < int'(SN); i++) sregs[i] = SDW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_freeze", 64'(freeze_req), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_valid", 64'(dif.out_valid), 64'(0));
    check("reset_last", 64'(dif.out_last), 64'(0));
    check("reset_addr", 64'(dif.out_addr), 64'(0));
    check("reset_data", 64'(dif.out_data), 64'(0));
    check("reset_checksum", 64'(checksum), 64'(0));
    check("reset_raddr", 64'(rf_raddr), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    ready_mode = 0;
    run_dump(-1, -1, 1, c1);
    ready_mode = 1;
    run_dump(-1, -1, 0, c2);
    check("backpressure_same_csum", 64'(c2), 64'(c1));
    ready_mode = 0;
    run_dump(10, -1, 1, c2);
    run_dump(-1, 5, 0, c2);

    for (int i = 0; i < int'(N); i++) regs[i] = DW'($urandom);
    ready_mode = 1;
    run_dump(-1, -1, 0, ca);
    old3    = regs[3];
    regs[3] = old3 ^ DW'($urandom_range(1, 32'hFFFF));
    repeat (3) @(posedge clk);
    #1;
    check("between_freeze", 64'(freeze_req), 64'(0));
    run_dump(-1, -1, 0, cb);
    check("csum_delta_r3", 64'(ca ^ cb), 64'(old3 ^ regs[3]));
    ready_mode = 0;

    // Narrow build: ready tied high, schedule follows the 2-cycle word rate.
    scs     = '0;
    for (int i = 0; i < int'(SN); i++) scs ^= sregs[i];
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    for (int n = 1; n <= 2 * int'(SN) + 2; n++) begin
      logic ev;
      int   k;
      @(posedge clk);
      #1;
      ev = (n % 2 == 1) && (n <= 2 * int'(SN) - 1);
      k  = (n - 1) / 2;
      check("s_valid", 64'(sif.out_valid), 64'(ev));
      check("s_done", 64'(s_done), 64'(n == 2 * int'(SN)));
      check("s_busy", 64'(s_busy), 64'(n <= 2 * int'(SN)));
      if (ev) begin
        check("s_addr", 64'(sif.out_addr), 64'(k));
        check("s_data", 64'(sif.out_data), 64'(sregs[k]));
        check("s_last", 64'(sif.out_last), 64'(k == int'(SN) - 1));
      end
    end
    check("s_checksum", 64'(s_checksum), 64'(scs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
